pad_oe_sequencer: RTL and testbench
===================================

PAD_OE_SEQUENCER -- requirements
Module: pad_oe_sequencer

Interface
REQ-001 SHALL have parameter NUM_GROUPS, default 8: number of output-pad groups sequenced (1..32).
REQ-002 SHALL have parameter GAP_W, default 8: width of the inter-group gap count.
REQ-003 SHALL have port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: ramp-up request, sampled each cycle.
REQ-006 SHALL have port stop, input, 1: ramp-down request, sampled each cycle.
REQ-007 SHALL have port group_mask, input, NUM_GROUPS: groups taking part in ramp-up, sampled only on start acceptance.
REQ-008 SHALL have port gap_cycles, input, GAP_W: spacing value, sampled on start or stop acceptance.
REQ-009 SHALL have port oe, output, NUM_GROUPS: per-group output enable to the pad frame, registered.
REQ-010 SHALL have port busy, output, 1: ramp in progress, registered.
REQ-011 SHALL have port done, output, 1: one-cycle ramp-complete pulse, registered.

Function
REQ-012 SHALL implement states OFF, RAMP_UP, ON and RAMP_DOWN.
REQ-013 In OFF, start=1 and stop=0 SHALL be accepted: mask and gap are captured and the state goes to RAMP_UP.
REQ-014 In ON, stop=1 SHALL be accepted: gap is captured and the state goes to RAMP_DOWN.
REQ-015 In RAMP_UP, stop=1 SHALL abort the ramp:
- gap is re-captured;
- the state goes to RAMP_DOWN;
- oe bits already set are kept;
- no done pulse is issued for the aborted ramp-up.
REQ-016 start and stop asserted in the same cycle: stop SHALL have priority and start SHALL be ignored; in OFF nothing is accepted.
REQ-017 Ignored requests SHALL be dropped without side effects:
- start outside OFF;
- stop in OFF;
- stop in RAMP_DOWN.
REQ-018 Ramp-up SHALL set oe bits for masked groups in ascending index order, one bit per step; unmasked groups consume no cycles.
REQ-019 Ramp-down SHALL clear the currently set oe bits in descending index order, one bit per step.
REQ-020 The first oe change SHALL be visible at cycle A+1, where A is the acceptance cycle.
REQ-021 Each later change SHALL occur gap_cycles+1 cycles after the previous one; gap_cycles=0 gives consecutive cycles, and the maximum gap SHALL NOT wrap.
REQ-022 done SHALL pulse high for exactly one cycle, one cycle after the last oe change.
REQ-023 In the done cycle the state SHALL be ON (after ramp-up) or OFF (after ramp-down).
REQ-024 Empty work SHALL skip straight to done:
- ramp-up with group_mask all zero, or ramp-down with oe all zero;
- done SHALL pulse at A+1 and oe SHALL stay unchanged.
REQ-025 busy SHALL be high from A+1 up to the cycle before done, and low in the done cycle and whenever the state is OFF or ON.
REQ-026 At most one oe bit SHALL change in any cycle.

Reset
REQ-027 reset low SHALL immediately force, regardless of clock:
- state OFF;
- oe all zero;
- busy 0, done 0;
- captured mask and gap zero;
- gap counter zero.
REQ-028 Reset asserted mid-ramp SHALL clear every oe bit at once; the post-reset state SHALL be OFF with no done pulse.
REQ-029 Release of reset SHALL be glitch-free: the first start SHALL be honoured in the first clock edge after reset deasserts.

Configuration
REQ-030 Macro PAD_OE_SEQ_ERR_EN, when defined, SHALL add output err (1 bit):
- err is a sticky flag, set the cycle after any ignored start or stop from REQ-017;
- err is cleared only by reset.
REQ-031 Without PAD_OE_SEQ_ERR_EN, port err and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Ramp-up, NUM_GROUPS=4, mask=4'b1011, gap=2, start at cycle 0 -> oe=0001@1, 0011@4, 1011@7; done@8; busy high 1..7.
REQ-033 Abort: same as REQ-032, stop at cycle 5 with gap=2 -> oe=0001@6, 0000@9; done@10 only; state OFF.
REQ-034 Empty mask, start at 0 -> done@1, oe stays 0, state ON; then stop at 3 -> done@4, state OFF.
REQ-035 gap=0, mask=4'b1111, ON then stop at 0 -> oe=0111@1, 0011@2, 0001@3, 0000@4; done@5.
REQ-036 Reset low at cycle 5 of the REQ-032 ramp -> oe=0 immediately; busy=0; start at first edge after release -> oe=0001 next cycle.
REQ-037 With PAD_OE_SEQ_ERR_EN, start during RAMP_UP -> err=1 next cycle and held until reset; ramp timing unchanged.

Source files
------------

// File: rtl/pad_oe_sequencer.sv
// Pad output-enable sequencer: ramps per-group OE up/down one group at a time with a programmable gap.
// Optional sticky error output for ignored requests is enabled by defining PAD_OE_SEQ_ERR_EN.
module pad_oe_sequencer #(
  parameter int NUM_GROUPS = 8,
  parameter int GAP_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [NUM_GROUPS-1:0] group_mask,
  input  logic [GAP_W-1:0]      gap_cycles,
  output logic [NUM_GROUPS-1:0] oe,
  output logic                  busy,
  output logic                  done
`ifdef PAD_OE_SEQ_ERR_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic [1:0] {
    S_OFF       = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_ON        = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_GROUPS-1:0]   mask_q, mask_d;
  logic [NUM_GROUPS-1:0]   oe_q, oe_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [GAP_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NUM_GROUPS-1:0]   remaining;

  function automatic logic [NUM_GROUPS-1:0] lowest_bit(input logic [NUM_GROUPS-1:0] v);
    return v & (~v + 1'b1);
  endfunction

  function automatic logic [NUM_GROUPS-1:0] highest_bit(input logic [NUM_GROUPS-1:0] v);
    logic [NUM_GROUPS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    oe_d      = oe_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    remaining = mask_q & ~oe_q;

    // The first OE step is taken on the accepting edge itself so it shows up at A+1.
    case (state_q)
      S_OFF: begin
        if (start && !stop) begin
          mask_d = group_mask;
          gap_d  = gap_cycles;
          cnt_d  = gap_cycles;
          if (group_mask == '0) begin
            state_d = S_ON;
            done_d  = 1'b1;
          end else begin
            oe_d    = oe_q | lowest_bit(group_mask);
            state_d = S_RAMP_UP;
            busy_d  = 1'b1;
          end
        end
      end

      S_RAMP_UP, S_ON: begin
        if (stop) begin
          gap_d = gap_cycles;
          cnt_d = gap_cycles;
          if (oe_q == '0) begin
            state_d = S_OFF;
            done_d  = 1'b1;
          end else begin
            oe_d    = oe_q & ~highest_bit(oe_q);
            state_d = S_RAMP_DOWN;
            busy_d  = 1'b1;
          end
        end else if (state_q == S_RAMP_UP) begin
          if (remaining == '0) begin
            state_d = S_ON;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
            if (cnt_q == '0) begin
              oe_d  = oe_q | lowest_bit(remaining);
              cnt_d = gap_q;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
      end

      S_RAMP_DOWN: begin
        if (oe_q == '0) begin
          state_d = S_OFF;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          if (cnt_q == '0) begin
            oe_d  = oe_q & ~highest_bit(oe_q);
            cnt_d = gap_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_OFF;
      mask_q  <= '0;
      oe_q    <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      oe_q    <= oe_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oe   = oe_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef PAD_OE_SEQ_ERR_EN
  logic err_q;
  logic ignored;

  assign ignored = (start && (state_q != S_OFF)) ||
                   (stop && ((state_q == S_OFF) || (state_q == S_RAMP_DOWN)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | ignored;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_pad_oe_sequencer.sv
// Bench for pad_oe_sequencer (NUM_GROUPS=4): directed scenarios plus random requests,
// compared each cycle against a schedule-based model of the ramp timing.
module tb_pad_oe_sequencer;

  localparam int NG = 4;
  localparam int GW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [NG-1:0] group_mask = '0;
  logic [GW-1:0] gap_cycles = '0;
  logic [NG-1:0] oe;
  logic          busy;
  logic          done;
`ifdef PAD_OE_SEQ_ERR_EN
  logic          err;
`endif

  pad_oe_sequencer #(.NUM_GROUPS(NG), .GAP_W(GW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .group_mask (group_mask),
    .gap_cycles (gap_cycles),
    .oe         (oe),
    .busy       (busy),
    .done       (done)
`ifdef PAD_OE_SEQ_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: 0=OFF 1=RAMP_UP 2=ON 3=RAMP_DOWN; ramps are a list of (time, bit) events.
  int            mstate = 0;
  logic [NG-1:0] moe    = '0;
  logic          mdone  = 1'b0;
  logic          merr   = 1'b0;
  int            done_t = 0;
  int            cyc    = 0;
  int            qt[$];
  int            qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mstate = 0; moe = '0; mdone = 1'b0; merr = 1'b0; done_t = 0;
    qt.delete(); qb.delete();
  endtask

  task automatic model_step();
    int t;
    cyc++;
    mdone = 1'b0;
    if ((start && mstate != 0) || (stop && (mstate == 0 || mstate == 3))) merr = 1'b1;
    if (mstate == 0 && start && !stop) begin
      qt.delete(); qb.delete();
      t = cyc;
      for (int i = 0; i < NG; i++)
        if (group_mask[i]) begin qt.push_back(t); qb.push_back(i); t += int'(gap_cycles) + 1; end
      if (qt.size() == 0) begin mdone = 1'b1; mstate = 2; end
      else begin mstate = 1; done_t = qt[$] + 1; end
    end else if ((mstate == 1 || mstate == 2) && stop) begin
      qt.delete(); qb.delete();
      t = cyc;
      for (int i = NG - 1; i >= 0; i--)
        if (moe[i]) begin qt.push_back(t); qb.push_back(i); t += int'(gap_cycles) + 1; end
      if (qt.size() == 0) begin mdone = 1'b1; mstate = 0; end
      else begin mstate = 3; done_t = qt[$] + 1; end
    end else if ((mstate == 1 || mstate == 3) && cyc == done_t) begin
      mdone  = 1'b1;
      mstate = (mstate == 1) ? 2 : 0;
    end
    while (qt.size() != 0 && qt[0] == cyc) begin
      moe[qb[0]] = (mstate == 1);
      void'(qt.pop_front());
      void'(qb.pop_front());
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".oe"},   32'(oe),   32'(moe));
    chk({tag, ".busy"}, 32'(busy), 32'(mstate == 1 || mstate == 3));
    chk({tag, ".done"}, 32'(done), 32'(mdone));
`ifdef PAD_OE_SEQ_ERR_EN
    chk({tag, ".err"},  32'(err),  32'(merr));
`endif
  endtask

  task automatic cycle(input string tag, input logic s, input logic p,
                       input logic [NG-1:0] m, input logic [GW-1:0] g);
    @(negedge clock);
    start = s; stop = p; group_mask = m; gap_cycles = g;
    @(posedge clock);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 4'b0000, 8'd0);
  endtask

  // Asynchronous reset mid-cycle, released before the next edge with a start already driven.
  task automatic reset_then_start(input string tag, input logic [NG-1:0] m, input logic [GW-1:0] g);
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    reset = 1'b0;
    #1;
    model_clear();
    check_outputs({tag, ".rst"});
    #2;
    reset = 1'b1;
    start = 1'b1; group_mask = m; gap_cycles = g;
    @(posedge clock);
    model_step();
    #1;
    check_outputs({tag, ".after"});
  endtask

  initial begin
    // Power-on reset, checked before any clock edge.
    #1;
    chk("por.oe",   32'(oe),   32'h0);
    chk("por.busy", 32'(busy), 32'h0);
    chk("por.done", 32'(done), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Ramp-up 1011 gap 2: oe 0001@1, 0011@4, 1011@7, done@8.
    cycle("up", 1'b1, 1'b0, 4'b1011, 8'd2);
    chk("up.first", 32'(oe), 32'h1);
    idle("up", 9);
    chk("up.final", 32'(oe), 32'hB);
    cycle("down", 1'b0, 1'b1, 4'b0000, 8'd1);
    idle("down", 8);
    chk("down.final", 32'(oe), 32'h0);

    // Abort: start at 0, stop at 5 -> 0001@6, 0000@9, done@10.
    cycle("abort", 1'b1, 1'b0, 4'b1011, 8'd2);
    idle("abort", 4);
    cycle("abort", 1'b0, 1'b1, 4'b0000, 8'd2);
    chk("abort.first", 32'(oe), 32'h1);
    idle("abort", 6);

    // Empty mask: done at A+1 into ON, then empty ramp-down.
    cycle("empty", 1'b1, 1'b0, 4'b0000, 8'd3);
    chk("empty.done", 32'(done), 32'h1);
    idle("empty", 2);
    cycle("empty", 1'b0, 1'b1, 4'b0000, 8'd3);
    chk("empty.done2", 32'(done), 32'h1);
    idle("empty", 2);

    // Gap 0 full mask up and down.
    cycle("gap0", 1'b1, 1'b0, 4'b1111, 8'd0);
    idle("gap0", 6);
    cycle("gap0", 1'b0, 1'b1, 4'b0000, 8'd0);
    chk("gap0.first", 32'(oe), 32'h7);
    idle("gap0", 6);

    // Ignored / simultaneous requests.
    cycle("both_off", 1'b1, 1'b1, 4'b1111, 8'd0);
    cycle("stop_off", 1'b0, 1'b1, 4'b1111, 8'd0);
    cycle("up2", 1'b1, 1'b0, 4'b0110, 8'd1);
    cycle("start_up", 1'b1, 1'b0, 4'b1111, 8'd0);
    idle("up2", 4);
    cycle("both_on", 1'b1, 1'b1, 4'b1111, 8'd1);
    cycle("stop_down", 1'b0, 1'b1, 4'b0000, 8'd0);
    idle("down2", 5);

    // Reset mid-ramp, then start on the first edge after release.
    cycle("rst", 1'b1, 1'b0, 4'b1011, 8'd2);
    idle("rst", 4);
    reset_then_start("rst", 4'b1011, 8'd2);
    chk("rst.restart", 32'(oe), 32'h1);
    idle("rst", 8);
    cycle("rst", 1'b0, 1'b1, 4'b0000, 8'd0);
    idle("rst", 5);

    // Maximum gap must not wrap.
    cycle("maxgap", 1'b1, 1'b0, 4'b0101, 8'd255);
    idle("maxgap", 259);
    cycle("maxgap", 1'b0, 1'b1, 4'b0000, 8'd0);
    idle("maxgap", 4);

    // Random requests.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand", ($urandom % 6) == 0, ($urandom % 12) == 0,
            NG'($urandom), GW'($urandom % 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
